stopwatch_core: RTL and testbench

Minutes:seconds stopwatch datapath that consumes the one-cycle tick pulses produced by the clock dividers and maintains four BCD digits for the seven-segment display stage. Supports run/pause toggling and an adjust mode in which the selected field increments at 2 Hz and blinks. Sits between the divider stage and the display multiplexer/decoder.

---
 rtl/stopwatch_core.sv | 142 ++++++++++++++
 tb/tb_stopwatch_core.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Minutes:seconds BCD stopwatch with a RUN/PAUSED state machine and a blinking
// adjust mode. Consumes the one-cycle 1 Hz / 2 Hz tick pulses from the dividers.
module stopwatch_core #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       blank_min,
   output logic       blank_sec,
   output logic       running
);

   localparam logic [3:0] LP_MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0] LP_MAX_ONES = 4'(MAX_MIN % 10);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_PAUSED = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   logic [3:0] r_min_tens;
   logic [3:0] r_min_ones;
   logic [3:0] r_sec_tens;
   logic [3:0] r_sec_ones;
   logic [3:0] w_min_tens_next;
   logic [3:0] w_min_ones_next;
   logic [3:0] w_sec_tens_next;
   logic [3:0] w_sec_ones_next;

   logic       r_adj_d;
   logic       r_phase;
   logic       r_blank_min;
   logic       r_blank_sec;
   logic       w_phase_next;
   logic       w_count_en;
   logic       w_inc_sec;
   logic       w_inc_min;
   logic       w_sec_at_max;
   logic       w_min_at_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Pause is locked out while adjusting so the pre-adjust state survives.
   always_comb begin
      w_state_next = r_state;
      if (pause && !adj) begin
         if (r_state == ST_RUN) begin
            w_state_next = ST_PAUSED;
         end else begin
            w_state_next = ST_RUN;
         end
      end
   end

   // Counting is qualified by the state before any coincident pause toggle.
   assign w_count_en   = ~adj & (r_state == ST_RUN) & tick_1hz;
   assign w_sec_at_max = (r_sec_tens >= 4'd5) && (r_sec_ones >= 4'd9);
   assign w_min_at_max = {r_min_tens, r_min_ones} >= {LP_MAX_TENS, LP_MAX_ONES};
   assign w_inc_sec    = w_count_en | (adj & sel & tick_2hz);
   assign w_inc_min    = (w_count_en & w_sec_at_max) | (adj & ~sel & tick_2hz);

   always_comb begin
      w_sec_tens_next = r_sec_tens;
      w_sec_ones_next = r_sec_ones;
      if (w_inc_sec) begin
         if (r_sec_ones >= 4'd9) begin
            w_sec_ones_next = 4'd0;
            w_sec_tens_next = (r_sec_tens >= 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
         end else begin
            w_sec_ones_next = r_sec_ones + 4'd1;
         end
      end
   end

   always_comb begin
      w_min_tens_next = r_min_tens;
      w_min_ones_next = r_min_ones;
      if (w_inc_min) begin
         if (w_min_at_max) begin
            w_min_tens_next = 4'd0;
            w_min_ones_next = 4'd0;
         end else if (r_min_ones >= 4'd9) begin
            w_min_ones_next = 4'd0;
            w_min_tens_next = r_min_tens + 4'd1;
         end else begin
            w_min_ones_next = r_min_ones + 4'd1;
         end
      end
   end

   // Entering adjust forces the visible phase so the field shows immediately.
   assign w_phase_next = (adj & ~r_adj_d) ? 1'b0 : (r_phase ^ tick_2hz);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min_tens  <= 4'd0;
         r_min_ones  <= 4'd0;
         r_sec_tens  <= 4'd0;
         r_sec_ones  <= 4'd0;
         r_adj_d     <= 1'b0;
         r_phase     <= 1'b0;
         r_blank_min <= 1'b0;
         r_blank_sec <= 1'b0;
      end else begin
         r_min_tens  <= w_min_tens_next;
         r_min_ones  <= w_min_ones_next;
         r_sec_tens  <= w_sec_tens_next;
         r_sec_ones  <= w_sec_ones_next;
         r_adj_d     <= adj;
         r_phase     <= w_phase_next;
         r_blank_min <= adj & ~sel & w_phase_next;
         r_blank_sec <= adj & sel & w_phase_next;
      end
   end

   assign min_tens  = r_min_tens;
   assign min_ones  = r_min_ones;
   assign sec_tens  = r_sec_tens;
   assign sec_ones  = r_sec_ones;
   assign blank_min = r_blank_min;
   assign blank_sec = r_blank_sec;
   assign running   = (r_state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: an integer-time model pushes the expected
// outputs per driven cycle; each test task pops and compares after the edge.
module tb_stopwatch_core;

   localparam int MAXM = 59;

   typedef struct packed {
      logic t1;
      logic t2;
      logic p;
      logic a;
      logic s;
   } stim_t;

   typedef struct packed {
      logic [15:0] digits;
      logic        bmin;
      logic        bsec;
      logic        run;
   } exp_t;

   logic clk;
   logic rst_n;
   logic tick_1hz, tick_2hz, pause, adj, sel;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic blank_min, blank_sec, running;

   logic t1_9, t2_9, p9, a9, s9;
   logic [3:0] mt9, mo9, st9, so9;
   logic bm9, bs9, run9;

   logic [18:0] obs;
   logic [15:0] obs9;
   assign obs  = {min_tens, min_ones, sec_tens, sec_ones, blank_min, blank_sec, running};
   assign obs9 = {mt9, mo9, st9, so9};

   int n_checks = 0;
   int n_fail   = 0;

   exp_t        sb[$];
   logic [15:0] sb9[$];

   int m_min, m_sec, m_phase, m_adj_prev;
   bit m_run;

   stopwatch_core #(.MAX_MIN(MAXM)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .pause(pause), .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
   );

   stopwatch_core #(.MAX_MIN(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .tick_1hz(t1_9), .tick_2hz(t2_9),
      .pause(p9), .adj(a9), .sel(s9),
      .min_tens(mt9), .min_ones(mo9), .sec_tens(st9), .sec_ones(so9),
      .blank_min(bm9), .blank_sec(bs9), .running(run9)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic stim_t mk(input logic t1, input logic t2, input logic p,
                                input logic a, input logic s);
      stim_t v;
      v.t1 = t1; v.t2 = t2; v.p = p; v.a = a; v.s = s;
      return v;
   endfunction

   function automatic void model_reset();
      m_min = 0; m_sec = 0; m_run = 1'b1; m_phase = 0; m_adj_prev = 0;
   endfunction

   function automatic int dut_secs();
      return (int'(min_tens) * 10 + int'(min_ones)) * 60 + int'(sec_tens) * 10 + int'(sec_ones);
   endfunction

   // Drive one cycle of stimulus, advance the model, push its expectation.
   task automatic drive(input stim_t v);
      exp_t e;
      tick_1hz = v.t1; tick_2hz = v.t2; pause = v.p; adj = v.a; sel = v.s;
      if (!v.a && m_run && v.t1) begin
         m_sec = m_sec + 1;
         if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min == MAXM) ? 0 : m_min + 1;
         end
      end
      if (v.a && v.t2) begin
         if (v.s) m_sec = (m_sec + 1) % 60;
         else     m_min = (m_min == MAXM) ? 0 : m_min + 1;
      end
      if (v.p && !v.a) m_run = ~m_run;
      if (v.a && m_adj_prev == 0) m_phase = 0;
      else if (v.t2)               m_phase = 1 - m_phase;
      m_adj_prev = int'(v.a);
      e.digits = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
      e.bmin   = v.a & ~v.s & (m_phase == 1);
      e.bsec   = v.a & v.s & (m_phase == 1);
      e.run    = m_run;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {tick_1hz, tick_2hz, pause, adj, sel} = '0;
      {t1_9, t2_9, p9, a9, s9} = '0;
      model_reset();
      #12;
      n_checks++;
      if (obs !== 19'b0000_0000_0000_0000_001) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected digits 0000, blanks 00, running 1", obs);
      end
      n_checks++;
      if ({obs9, bm9, bs9, run9} !== 19'b0000_0000_0000_0000_001) begin
         n_fail++;
         $display("FAIL reset_state_max9: got %h expected 00001", {obs9, bm9, bs9, run9});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_count();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      for (int i = 0; i < 75; i++) begin
         st.push_back(mk(1, 0, 0, 0, 0));
         st.push_back(mk(0, 0, 0, 0, 0));
      end
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL count step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if ({obs[18:3], obs[0]} !== {16'h0115, 1'b1}) begin
         n_fail++;
         $display("FAIL count_75: got %h run %b expected 0115 run 1", obs[18:3], obs[0]);
      end
   endtask

   task automatic test_wrap();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      int    n_min = (MAXM - m_min + 60) % 60;
      int    n_sec = (58 - m_sec + 60) % 60;
      for (int i = 0; i < n_min; i++) st.push_back(mk(0, 1, 0, 1, 0));
      for (int i = 0; i < n_sec; i++) st.push_back(mk(0, 1, 0, 1, 1));
      st.push_back(mk(0, 0, 0, 0, 0));
      st.push_back(mk(1, 0, 0, 0, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL wrap_preload step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if (obs[18:3] !== 16'h5959) begin
         n_fail++;
         $display("FAIL wrap_5959: got %h expected 5959", obs[18:3]);
      end
      st.push_back(mk(0, 0, 0, 0, 0));
      st.push_back(mk(1, 0, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL wrap step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if (obs[18:3] !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_0000: got %h expected 0000", obs[18:3]);
      end
   endtask

   task automatic test_max_min9();
      logic [15:0] x;
      a9 = 1'b1;
      s9 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         t2_9 = 1'b1; @(posedge clk); #1;
         t2_9 = 1'b0; @(posedge clk); #1;
      end
      s9 = 1'b1;
      for (int i = 0; i < 58; i++) begin
         t2_9 = 1'b1; @(posedge clk); #1;
         t2_9 = 1'b0; @(posedge clk); #1;
      end
      a9 = 1'b0;
      sb9.push_back(16'h0958);
      @(posedge clk); #1;
      x = sb9.pop_front();
      n_checks++;
      if (obs9 !== x) begin
         n_fail++;
         $display("FAIL max9_preload: got %h expected %h", obs9, x);
      end
      for (int i = 0; i < 2; i++) begin
         t1_9 = 1'b1;
         sb9.push_back(i == 0 ? 16'h0959 : 16'h0000);
         @(posedge clk); #1;
         t1_9 = 1'b0;
         x = sb9.pop_front();
         n_checks++;
         if (obs9 !== x) begin
            n_fail++;
            $display("FAIL max9_tick %0d: got %h expected %h", i, obs9, x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pause();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      int    t0 = dut_secs();
      st.push_back(mk(0, 0, 1, 0, 0));
      for (int i = 0; i < 10; i++) begin
         st.push_back(mk(1, 0, 0, 0, 0));
         st.push_back(mk(0, 0, 0, 0, 0));
      end
      st.push_back(mk(0, 0, 1, 0, 0));
      for (int i = 0; i < 3; i++) begin
         st.push_back(mk(1, 0, 0, 0, 0));
         st.push_back(mk(0, 0, 0, 0, 0));
      end
      st.push_back(mk(1, 0, 1, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 0));
      st.push_back(mk(1, 0, 1, 0, 0));
      st.push_back(mk(0, 0, 0, 0, 0));
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL pause step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if (dut_secs() !== (t0 + 4) % 3600 || running !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_total: got %0d s run %b expected %0d s run 1", dut_secs(), running, (t0 + 4) % 3600);
      end
   endtask

   task automatic test_adjust_sec();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      int    n_sec = (58 - m_sec + 60) % 60;
      logic [7:0] min_saved;
      for (int i = 0; i < n_sec; i++) st.push_back(mk(0, 1, 0, 1, 1));
      st.push_back(mk(0, 0, 0, 0, 1));
      st.push_back(mk(1, 0, 0, 1, 1));
      for (int i = 0; i < 3; i++) begin
         st.push_back(mk(1, 1, 0, 1, 1));
         st.push_back(mk(1, 0, 0, 1, 1));
      end
      min_saved = 8'(m_min / 10 * 16 + m_min % 10);
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL adjust_sec step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if ({obs[18:3], obs[2:1]} !== {min_saved, 8'h01, 2'b01}) begin
         n_fail++;
         $display("FAIL adjust_sec_final: got %h blanks %b expected %h01 blanks 01", obs[18:3], obs[2:1], min_saved);
      end
   endtask

   task automatic test_adjust_min();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      int    n_min = (MAXM - m_min + 60) % 60;
      logic [7:0] sec_saved;
      logic run_saved;
      for (int i = 0; i < n_min; i++) st.push_back(mk(0, 1, 0, 1, 0));
      for (int i = 0; i < 3; i++) begin
         st.push_back(mk(0, 0, 1, 1, 0));
         st.push_back(mk(0, 0, 0, 1, 0));
      end
      st.push_back(mk(0, 1, 0, 1, 0));
      sec_saved = 8'(m_sec / 10 * 16 + m_sec % 10);
      run_saved = m_run;
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL adjust_min step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if ({obs[18:3], obs[0]} !== {8'h00, sec_saved, run_saved}) begin
         n_fail++;
         $display("FAIL adjust_min_wrap: got %h run %b expected 00%h run %b", obs[18:3], obs[0], sec_saved, run_saved);
      end
      drive(mk(0, 0, 0, 0, 0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
         n_fail++;
         $display("FAIL adjust_exit: got %h expected %h", obs, {e.digits, e.bmin, e.bsec, e.run});
      end
   endtask

   task automatic test_async_reset();
      stim_t st[$];
      exp_t  e;
      int    k = 0;
      int    n_min = (12 - m_min + 60) % 60;
      int    n_sec = (34 - m_sec + 60) % 60;
      if ((n_min + n_sec) % 2 == 0 || n_sec == 0) begin
         st.push_back(mk(1, 0, 0, 0, 0));
         st.push_back(mk(0, 0, 0, 0, 0));
         n_sec = (n_sec + 59) % 60;
      end
      st.push_back(mk(0, 0, 0, 1, 0));
      for (int i = 0; i < n_min; i++) st.push_back(mk(0, 1, 0, 1, 0));
      for (int i = 0; i < n_sec; i++) st.push_back(mk(0, 1, 0, 1, 1));
      while (st.size() > 0) begin
         drive(st.pop_front());
         e = sb.pop_front();
         n_checks++;
         if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
            n_fail++;
            $display("FAIL async_preload step %0d: got %h expected %h", k, obs, {e.digits, e.bmin, e.bsec, e.run});
         end
         k++;
      end
      n_checks++;
      if ({obs[18:3], obs[1]} !== {16'h1234, 1'b1}) begin
         n_fail++;
         $display("FAIL async_preload_1234: got %h blank_sec %b expected 1234 blank_sec 1", obs[18:3], obs[1]);
      end
      #2;
      {tick_1hz, tick_2hz, pause, adj, sel} = '0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 19'b0000_0000_0000_0000_001) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected 0000 blanks 00 running 1", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(mk(0, 0, 0, 0, 0));
      e = sb.pop_front();
      n_checks++;
      if (obs !== {e.digits, e.bmin, e.bsec, e.run}) begin
         n_fail++;
         $display("FAIL after_reset: got %h expected %h", obs, {e.digits, e.bmin, e.bsec, e.run});
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_max_min9();
      test_pause();
      test_adjust_sec();
      test_adjust_min();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
